// File: rtl/countdown_timer.sv
`default_nettype none
// countdown_timer: MM:SS kitchen-style countdown, button-set, active-low 7-segment outputs (rev 1.0).
// Optional macro BLINK_DONE_EN: displays flash "0"/blank every CLK_DIV/2 cycles while in DONE.
module countdown_timer #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [6:0] disp1,
    output logic [6:0] disp2,
    output logic [6:0] disp3,
    output logic [6:0] disp4,
    output logic       running,
    output logic       done
);
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic [2:0]    s1_q, s2_q, s3_q;
    logic [2:0]    evt;
    logic          ev_start, ev_min, ev_sec;
    logic [3:0]    ss_u_q, ss_t_q, mm_u_q, mm_t_q;
    logic [3:0]    ss_u_d, ss_t_d, mm_u_d, mm_t_d;
    logic [3:0]    dec_ss_u, dec_ss_t, dec_mm_u, dec_mm_t;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick, time_zero, dec_zero, blank_now;
    logic [6:0]    disp1_q, disp2_q, disp3_q, disp4_q;

    // Two sync flops, third flop holds the previous synced level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {btn_start, btn_min, btn_sec};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign evt      = s2_q & ~s3_q;
    assign ev_start = evt[2];
    assign ev_min   = evt[1];
    assign ev_sec   = evt[0];

    assign tick      = (state_q == S_RUN) && (presc_q == PW'(CLK_DIV - 1));
    assign time_zero = (ss_u_q == 4'd0) && (ss_t_q == 4'd0) && (mm_u_q == 4'd0) && (mm_t_q == 4'd0);

    always_comb begin
        dec_ss_u = ss_u_q - 4'd1;
        dec_ss_t = ss_t_q;
        dec_mm_u = mm_u_q;
        dec_mm_t = mm_t_q;
        if (ss_u_q == 4'd0) begin
            dec_ss_u = 4'd9;
            dec_ss_t = ss_t_q - 4'd1;
            if (ss_t_q == 4'd0) begin
                dec_ss_t = 4'd5;
                dec_mm_u = mm_u_q - 4'd1;
                if (mm_u_q == 4'd0) begin
                    dec_mm_u = 4'd9;
                    dec_mm_t = mm_t_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (dec_ss_u == 4'd0) && (dec_ss_t == 4'd0) && (dec_mm_u == 4'd0) && (dec_mm_t == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ev_start && !time_zero) state_d = S_RUN;
            S_RUN: begin
                if (tick && dec_zero) state_d = S_DONE;
                else if (ev_start)    state_d = S_PAUSE;
            end
            S_PAUSE: if (ev_start) state_d = S_RUN;
            S_DONE:  if (ev_start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == S_RUN);
        done    = (state_q == S_DONE);
    end

    // Set buttons are discarded when start fires in the same cycle.
    always_comb begin
        ss_u_d = ss_u_q;
        ss_t_d = ss_t_q;
        mm_u_d = mm_u_q;
        mm_t_d = mm_t_q;
        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (!ev_start && ev_sec) begin
                    if (ss_u_q == 4'd9) begin
                        ss_u_d = 4'd0;
                        ss_t_d = (ss_t_q == 4'd5) ? 4'd0 : ss_t_q + 4'd1;
                    end else begin
                        ss_u_d = ss_u_q + 4'd1;
                    end
                end
                if (!ev_start && ev_min) begin
                    if (mm_u_q == 4'd9) begin
                        mm_u_d = 4'd0;
                        mm_t_d = (mm_t_q == 4'd5) ? 4'd0 : mm_t_q + 4'd1;
                    end else begin
                        mm_u_d = mm_u_q + 4'd1;
                    end
                end
            end
            S_RUN: begin
                if (tick) begin
                    ss_u_d = dec_ss_u;
                    ss_t_d = dec_ss_t;
                    mm_u_d = dec_mm_u;
                    mm_t_d = dec_mm_t;
                end
            end
            default: ;
        endcase
        presc_d = (state_q == S_RUN && state_d == S_RUN && !tick) ? presc_q + PW'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ss_u_q  <= '0;
            ss_t_q  <= '0;
            mm_u_q  <= '0;
            mm_t_q  <= '0;
            presc_q <= '0;
        end else begin
            ss_u_q  <= ss_u_d;
            ss_t_q  <= ss_t_d;
            mm_u_q  <= mm_u_d;
            mm_t_q  <= mm_t_d;
            presc_q <= presc_d;
        end
    end

`ifdef BLINK_DONE_EN
    localparam int HALF = CLK_DIV / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blank_q;

    // Phase starts blank on every DONE entry and flips after each half period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b1;
        end else if (state_q != S_DONE) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b1;
        end else if (blink_cnt_q == BW'(HALF - 1)) begin
            blink_cnt_q <= '0;
            blank_q     <= ~blank_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign blank_now = (state_q == S_DONE) && blank_q;
`else
    assign blank_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp1_q <= SEG_ZERO;
            disp2_q <= SEG_ZERO;
            disp3_q <= SEG_ZERO;
            disp4_q <= SEG_ZERO;
        end else if (blank_now) begin
            disp1_q <= SEG_BLANK;
            disp2_q <= SEG_BLANK;
            disp3_q <= SEG_BLANK;
            disp4_q <= SEG_BLANK;
        end else begin
            disp1_q <= seg7(ss_u_q);
            disp2_q <= seg7(ss_t_q);
            disp3_q <= seg7(mm_u_q);
            disp4_q <= seg7(mm_t_q);
        end
    end

    assign disp1 = disp1_q;
    assign disp2 = disp2_q;
    assign disp3 = disp3_q;
    assign disp4 = disp4_q;

endmodule
`default_nettype wire
